rx_pll_ctrl: RTL and testbench

Reset/lock sequencer for the LVDS receive PLL. It drives the PLL's active-high `pllreset`, synchronises and qualifies the PLL `lock` output, and releases the LVDS RX datapath reset only after lock has been stable. It also detects loss of lock and bounds relock attempts with a timeout and retry limit. The block sits between the RX PLL instance and the deserialiser/word-alignment logic, clocked from a free-running clock that is independent of the PLL outputs.

---
 rtl/rx_pll_ctrl.sv | 157 +++++++++++++++
 tb/tb_rx_pll_ctrl.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rx_pll_ctrl.sv
// rx_pll_ctrl: reset/lock sequencer for the LVDS receive PLL.
// Pulses the PLL reset, qualifies the synchronised lock indication, releases
// the RX datapath reset once lock is stable, and bounds relock attempts.
module rx_pll_ctrl #(
    parameter int RST_HOLD_CYCLES     = 16,
    parameter int LOCK_STABLE_CYCLES  = 1024,
    parameter int LOCK_TIMEOUT_CYCLES = 65536,
    parameter int MAX_RETRIES         = 3,
    parameter int CNT_W               = 17
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       pll_lock,
    output logic       pll_reset,
    output logic       lvds_rst,
    output logic       ready,
    output logic       fail,
    output logic [7:0] retry_cnt,
    output logic [7:0] lol_cnt,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_RESET  = 3'd1,
        S_WAIT   = 3'd2,
        S_STABLE = 3'd3,
        S_RUN    = 3'd4,
        S_FAIL   = 3'd5
    } state_t;

    // Terminal counts: each state ends when the counter hits its last value,
    // so the counter can never wrap.
    localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(RST_HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [7:0]       RETRY_LIMIT  = 8'(MAX_RETRIES);

    state_t           state_q;
    state_t           state_n;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_n;
    logic [7:0]       retry_q;
    logic [7:0]       retry_n;
    logic [7:0]       lol_q;
    logic [7:0]       lol_n;
    logic             sync1;
    logic             lock_s;

    // Next-state, counter, retry and loss-of-lock bookkeeping.
    always_comb begin
        state_n = state_q;
        cnt_n   = cnt_q;
        retry_n = retry_q;
        lol_n   = lol_q;
        if (!en) begin
            state_n = S_IDLE;
            cnt_n   = '0;
            retry_n = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    cnt_n   = '0;
                    retry_n = '0;
                    state_n = S_RESET;
                end
                S_RESET: begin
                    if (cnt_q == RST_LAST) begin
                        state_n = S_WAIT;
                        cnt_n   = '0;
                    end else begin
                        cnt_n = cnt_q + 1'b1;
                    end
                end
                S_WAIT: begin
                    if (lock_s) begin
                        state_n = S_STABLE;
                        cnt_n   = '0;
                    end else if (cnt_q == TIMEOUT_LAST) begin
                        cnt_n = '0;
                        if (retry_q == RETRY_LIMIT) begin
                            state_n = S_FAIL;
                        end else begin
                            retry_n = retry_q + 1'b1;
                            state_n = S_RESET;
                        end
                    end else begin
                        cnt_n = cnt_q + 1'b1;
                    end
                end
                S_STABLE: begin
                    if (!lock_s) begin
                        state_n = S_WAIT;
                        cnt_n   = '0;
                    end else if (cnt_q == STABLE_LAST) begin
                        state_n = S_RUN;
                        cnt_n   = '0;
                    end else begin
                        cnt_n = cnt_q + 1'b1;
                    end
                end
                S_RUN: begin
                    if (!lock_s) begin
                        state_n = S_RESET;
                        cnt_n   = '0;
                        retry_n = '0;
                        if (lol_q != 8'hFF) begin
                            lol_n = lol_q + 1'b1;
                        end
                    end
                end
                S_FAIL: begin
                    state_n = S_FAIL;
                end
                default: begin
                    state_n = S_IDLE;
                    cnt_n   = '0;
                    retry_n = '0;
                end
            endcase
        end
    end

    // Lock synchroniser, FSM registers, and Moore outputs decoded from the
    // next state so they switch on the same edge as the state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1     <= 1'b0;
            lock_s    <= 1'b0;
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            retry_q   <= '0;
            lol_q     <= '0;
            pll_reset <= 1'b1;
            lvds_rst  <= 1'b1;
            ready     <= 1'b0;
            fail      <= 1'b0;
        end else begin
            sync1     <= pll_lock;
            lock_s    <= sync1;
            state_q   <= state_n;
            cnt_q     <= cnt_n;
            retry_q   <= retry_n;
            lol_q     <= lol_n;
            pll_reset <= (state_n == S_IDLE) || (state_n == S_RESET) || (state_n == S_FAIL);
            lvds_rst  <= (state_n != S_RUN);
            ready     <= (state_n == S_RUN);
            fail      <= (state_n == S_FAIL);
        end
    end

    assign retry_cnt = retry_q;
    assign lol_cnt   = lol_q;
    assign state     = state_q;

endmodule

// File: tb/tb_rx_pll_ctrl.sv
// tb_rx_pll_ctrl: directed bench for rx_pll_ctrl with small timing parameters
// (reset hold 4, stable 8, timeout 32, two retries).
module tb_rx_pll_ctrl;

    logic       clk;
    logic       rst;
    logic       en;
    logic       pll_lock;
    logic       pll_reset;
    logic       lvds_rst;
    logic       ready;
    logic       fail;
    logic [7:0] retry_cnt;
    logic [7:0] lol_cnt;
    logic [2:0] state;

    int testsRun    = 0;
    int testsFailed = 0;

    rx_pll_ctrl #(
        .RST_HOLD_CYCLES    (4),
        .LOCK_STABLE_CYCLES (8),
        .LOCK_TIMEOUT_CYCLES(32),
        .MAX_RETRIES        (2),
        .CNT_W              (17)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .pll_lock (pll_lock),
        .pll_reset(pll_reset),
        .lvds_rst (lvds_rst),
        .ready    (ready),
        .fail     (fail),
        .retry_cnt(retry_cnt),
        .lol_cnt  (lol_cnt),
        .state    (state)
    );

    // Free-running controller clock, 10 time-unit period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Compare one observed value against its expected value and log mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        testsRun++;
        if (got !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive en and pll_lock, then let n clock edges pass.
    task automatic applyStimulus(input logic enV, input logic lockV, input int n);
        en       = enV;
        pll_lock = lockV;
        for (int i = 0; i < n; i++) begin
            tick();
        end
    endtask

    // Wait for ready with a bounded cycle budget; an expired budget is a failure.
    task automatic waitReady(input string tag, input int maxCycles);
        int n;
        n = 0;
        while (!ready && n < maxCycles) begin
            tick();
            n++;
        end
        if (!ready) begin
            checkOutput(tag, 32'(ready), 32'd1);
        end
    endtask

    initial begin
        int fallCount;
        int highCount;
        int readySeen;
        logic prevReset;
        logic fail107;
        logic fail108;
        logic [2:0] state108;
        logic [7:0] retry108;
        logic reset108;
        logic [7:0] lol1;
        logic [7:0] lol255;

        rst      = 1'b1;
        en       = 1'b0;
        pll_lock = 1'b0;

        // Reset values
        #1;
        checkOutput("rst_state", 32'(state), 32'd0);
        checkOutput("rst_pll_reset", 32'(pll_reset), 32'd1);
        checkOutput("rst_lvds_rst", 32'(lvds_rst), 32'd1);
        checkOutput("rst_ready", 32'(ready), 32'd0);
        checkOutput("rst_fail", 32'(fail), 32'd0);
        checkOutput("rst_retry", 32'(retry_cnt), 32'd0);
        checkOutput("rst_lol", 32'(lol_cnt), 32'd0);
        tick();
        tick();
        rst = 1'b0;
        tick();
        checkOutput("idle_state", 32'(state), 32'd0);

        // Normal lock
        applyStimulus(1'b1, 1'b0, 1);
        checkOutput("n_reset_entry", 32'(state), 32'd1);
        applyStimulus(1'b1, 1'b0, 3);
        checkOutput("n_pllrst_hold3", 32'(pll_reset), 32'd1);
        applyStimulus(1'b1, 1'b0, 1);
        checkOutput("n_pllrst_fall4", 32'(pll_reset), 32'd0);
        checkOutput("n_wait_state", 32'(state), 32'd2);
        applyStimulus(1'b1, 1'b0, 9);
        applyStimulus(1'b1, 1'b1, 3);
        checkOutput("n_stable_entry", 32'(state), 32'd3);
        applyStimulus(1'b1, 1'b1, 7);
        checkOutput("n_ready_early", 32'(ready), 32'd0);
        applyStimulus(1'b1, 1'b1, 1);
        checkOutput("n_ready_11", 32'(ready), 32'd1);
        checkOutput("n_lvds_rst_11", 32'(lvds_rst), 32'd0);
        checkOutput("n_retry", 32'(retry_cnt), 32'd0);

        // Loss of lock in RUN
        applyStimulus(1'b1, 1'b0, 2);
        checkOutput("lol_ready_2", 32'(ready), 32'd1);
        applyStimulus(1'b1, 1'b0, 1);
        checkOutput("lol_ready_3", 32'(ready), 32'd0);
        checkOutput("lol_lvds_rst_3", 32'(lvds_rst), 32'd1);
        checkOutput("lol_state_3", 32'(state), 32'd1);
        checkOutput("lol_cnt_1", 32'(lol_cnt), 32'd1);
        applyStimulus(1'b1, 1'b0, 3);
        checkOutput("lol_pllrst_hold", 32'(pll_reset), 32'd1);
        applyStimulus(1'b1, 1'b0, 1);
        checkOutput("lol_pllrst_fall", 32'(pll_reset), 32'd0);
        applyStimulus(1'b1, 1'b0, 13);

        // Relock, then a 3-cycle lock glitch during STABLE
        applyStimulus(1'b1, 1'b1, 3);
        checkOutput("g_stable_entry", 32'(state), 32'd3);
        applyStimulus(1'b1, 1'b1, 2);
        applyStimulus(1'b1, 1'b0, 3);
        checkOutput("g_back_to_wait", 32'(state), 32'd2);
        checkOutput("g_retry", 32'(retry_cnt), 32'd0);
        applyStimulus(1'b1, 1'b1, 3);
        checkOutput("g_stable_reentry", 32'(state), 32'd3);
        applyStimulus(1'b1, 1'b1, 7);
        checkOutput("g_ready_early", 32'(ready), 32'd0);
        applyStimulus(1'b1, 1'b1, 1);
        checkOutput("g_ready_8", 32'(ready), 32'd1);

        // en dropped in WAIT_LOCK after one retry
        applyStimulus(1'b1, 1'b0, 3);
        checkOutput("e_lol_cnt_2", 32'(lol_cnt), 32'd2);
        applyStimulus(1'b1, 1'b0, 36);
        checkOutput("e_retry_1", 32'(retry_cnt), 32'd1);
        checkOutput("e_retry_state", 32'(state), 32'd1);
        applyStimulus(1'b1, 1'b0, 6);
        checkOutput("e_in_wait", 32'(state), 32'd2);
        applyStimulus(1'b0, 1'b0, 1);
        checkOutput("e_idle", 32'(state), 32'd0);
        checkOutput("e_retry_clr", 32'(retry_cnt), 32'd0);
        checkOutput("e_pll_reset", 32'(pll_reset), 32'd1);
        checkOutput("e_lol_kept", 32'(lol_cnt), 32'd2);

        // Never locks: three attempts of 4+32 cycles, FAIL at 108
        fallCount = 0;
        highCount = 0;
        readySeen = 0;
        prevReset = pll_reset;
        fail107   = 1'b0;
        fail108   = 1'b0;
        state108  = 3'd0;
        retry108  = 8'd0;
        reset108  = 1'b0;
        for (int i = 0; i <= 108; i++) begin
            applyStimulus(1'b1, 1'b0, 1);
            if (prevReset && !pll_reset) fallCount++;
            if (i < 108 && pll_reset) highCount++;
            if (ready) readySeen++;
            if (i == 107) fail107 = fail;
            if (i == 108) begin
                fail108  = fail;
                state108 = state;
                retry108 = retry_cnt;
                reset108 = pll_reset;
            end
            prevReset = pll_reset;
        end
        checkOutput("f_pulses", 32'(fallCount), 32'd3);
        checkOutput("f_high_cycles", 32'(highCount), 32'd12);
        checkOutput("f_ready_seen", 32'(readySeen), 32'd0);
        checkOutput("f_fail_107", 32'(fail107), 32'd0);
        checkOutput("f_fail_108", 32'(fail108), 32'd1);
        checkOutput("f_state_108", 32'(state108), 32'd5);
        checkOutput("f_retry_108", 32'(retry108), 32'd2);
        checkOutput("f_pllrst_108", 32'(reset108), 32'd1);
        applyStimulus(1'b1, 1'b0, 5);
        checkOutput("f_hold", 32'(fail), 32'd1);
        applyStimulus(1'b0, 1'b0, 1);
        checkOutput("f_exit_idle", 32'(state), 32'd0);
        checkOutput("f_exit_fail", 32'(fail), 32'd0);

        // Asynchronous rst pulse while in RUN
        applyStimulus(1'b1, 1'b1, 1);
        waitReady("r_ready_timeout", 40);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("r_state", 32'(state), 32'd0);
        checkOutput("r_pll_reset", 32'(pll_reset), 32'd1);
        checkOutput("r_lvds_rst", 32'(lvds_rst), 32'd1);
        checkOutput("r_ready", 32'(ready), 32'd0);
        checkOutput("r_lol", 32'(lol_cnt), 32'd0);
        tick();
        rst = 1'b0;

        // lol_cnt saturation over 256 loss-of-lock events
        waitReady("s_ready_timeout", 40);
        lol1   = 8'd0;
        lol255 = 8'd0;
        for (int e = 1; e <= 256; e++) begin
            applyStimulus(1'b1, 1'b0, 3);
            if (e == 1) lol1 = lol_cnt;
            if (e == 255) lol255 = lol_cnt;
            applyStimulus(1'b1, 1'b1, 0);
            waitReady("s_relock_timeout", 40);
        end
        checkOutput("s_lol_1", 32'(lol1), 32'd1);
        checkOutput("s_lol_255", 32'(lol255), 32'd255);
        checkOutput("s_lol_256", 32'(lol_cnt), 32'd255);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
